// File: rtl/prg_mem_port.sv
// prg_mem_port: per-CPU-cycle memory responder between the active mapper and the SDRAM arbiter.
// Optional mem_ack timeout with sticky err flag is enabled by defining PRG_MEM_TIMEOUT_EN.
module prg_mem_port #(
  parameter int unsigned ADDR_BITS   = 23,
  parameter int unsigned SETTLE      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m2,
  input  logic                 cpu_rw,
  input  logic [7:0]           cpu_data_in,
  input  logic [ADDR_BITS-1:0] prg_addr,
  input  logic                 prg_oe,
  input  logic                 prg_we,
  input  logic                 wram_ce,
  output logic [7:0]           cpu_data_out,
  output logic                 cpu_data_oe,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 err
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 1) begin : g_settle_chk
    $error("prg_mem_port: SETTLE must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("prg_mem_port: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_tmo_chk
    $error("prg_mem_port: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RD_REQ,
    S_DRIVE,
    S_WR_WAIT,
    S_WR_REQ,
    S_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] m2_sync;
  logic                   m2_q;
  logic                   m2_s;
  logic                   rise;
  logic                   fall;
  logic                   fall_next;
  logic [SW-1:0]          settle_cnt;
  logic [7:0]             data_cap;
  logic                   pending;

  // Synchronizer is deliberately not reset so a reset inside a CPU cycle cannot fake a rise event.
  always_ff @(posedge clk) begin
    m2_sync <= {m2_sync[SYNC_STAGES-2:0], m2};
    m2_q    <= m2_sync[SYNC_STAGES-1];
  end

  assign m2_s      = m2_sync[SYNC_STAGES-1];
  assign rise      = m2_s & ~m2_q;
  assign fall      = ~m2_s & m2_q;
  // High when m2_s is about to drop; lets the drive enable fall together with m2_s.
  assign fall_next = m2_s & ~m2_sync[SYNC_STAGES-2];

  always_ff @(posedge clk) begin
    if (reset) begin
      data_cap <= '0;
    end else if (m2_s) begin
      data_cap <= cpu_data_in;
    end
  end

`ifdef PRG_MEM_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_cnt;
`endif

  // Cycle sequencer and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      pending      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_data_out <= 8'h00;
      cpu_data_oe  <= 1'b0;
      err          <= 1'b0;
`ifdef PRG_MEM_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rise) begin
            settle_cnt <= SW'(SETTLE - 1);
            state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (fall) begin
            state <= S_IDLE;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
          end else begin
            mem_addr <= prg_addr;
            if (cpu_rw && prg_oe) begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              state   <= S_RD_REQ;
`ifdef PRG_MEM_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else if (!cpu_rw && (prg_we || wram_ce)) begin
              state <= S_WR_WAIT;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_RD_REQ: begin
          if (fall) begin
            // Cycle too short: abandon the request; a later ack lands in IDLE and is ignored.
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end else if (mem_ack) begin
            mem_req      <= 1'b0;
            cpu_data_out <= mem_rdata;
            cpu_data_oe  <= ~fall_next;
            state        <= S_DRIVE;
          end
`ifdef PRG_MEM_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            mem_req      <= 1'b0;
            err          <= 1'b1;
            cpu_data_out <= 8'hFF;
            cpu_data_oe  <= ~fall_next;
            state        <= S_DRIVE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end

        S_DRIVE: begin
          if (fall || fall_next) begin
            cpu_data_oe <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cpu_data_oe <= 1'b1;
          end
        end

        S_WR_WAIT: begin
          if (fall) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= data_cap;
            state     <= S_WR_REQ;
`ifdef PRG_MEM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end

        S_WR_REQ: begin
          if (rise) begin
            pending <= 1'b1;
          end else if (fall) begin
            pending <= 1'b0;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pending <= 1'b0;
            // A CPU cycle that started during the write is picked up now if M2 is still high.
            if ((pending || rise) && m2_s) begin
              settle_cnt <= SW'(SETTLE - 1);
              state      <= S_SETTLE;
            end else begin
              state <= S_IDLE;
            end
          end
`ifdef PRG_MEM_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pending <= 1'b0;
            err     <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end

        S_DONE: begin
          if (fall) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
